// File: rtl/iob_mem_responder_pkg.sv
// Shared definitions for the IOb memory responder: request/response field
// layout helpers and the responder FSM state encoding.
package iob_mem_responder_pkg;

  // FSM state encoding
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } resp_state_e;

  // Request bus {avalid, address, wdata, wstrb}, wstrb in the LSBs
  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  localparam int REQ_WSTRB_LSB = 0;

  function automatic int req_wdata_lsb(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int req_addr_lsb(input int data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int req_avalid_bit(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

  // Response bus {rdata, rvalid, ready}, ready in the LSB
  function automatic int resp_w(input int data_w);
    return data_w + 2;
  endfunction

  localparam int RESP_READY_BIT  = 0;
  localparam int RESP_RVALID_BIT = 1;
  localparam int RESP_RDATA_LSB  = 2;

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port RAM with per-byte write enables and a registered read port.
// The read register only updates on a read, so it holds the last read word.
module iob_ram_sp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en_i,
  input  logic [DATA_W/8-1:0]   we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     d_i,
  output logic [DATA_W-1:0]     d_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane writes; the array itself is never reset
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < NB; b++) begin
        if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= d_i[b*8 +: 8];
      end
    end
  end

  // Registered read, loaded only when a read is issued
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  rdata_q <= '0;
    else if (en_i && we_i == '0)  rdata_q <= mem_q[addr_i];
  end

  assign d_o = rdata_q;

endmodule

// File: rtl/iob_mem_responder.sv
// IOb native bus responder backed by a byte-enabled single-port RAM.
// Optional wait-state engine compiled in with `define IOB_MEM_RESP_WAIT_EN;
// without it ready is tied high and reads answer one cycle after acceptance.
module iob_mem_responder
  import iob_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [req_w(ADDR_W, DATA_W)-1:0]  req,
  output logic [resp_w(DATA_W)-1:0]         resp
);

  localparam int STRB_W = DATA_W / 8;

`ifdef IOB_MEM_RESP_WAIT_EN
  localparam int W_EFF = WAIT_CYCLES;
`else
  localparam int W_EFF = 0;
  logic [31:0] unused_wait;
  assign unused_wait = WAIT_CYCLES;
`endif

  logic              req_avalid;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;

  assign req_avalid = req[req_avalid_bit(ADDR_W, DATA_W)];
  assign req_addr   = req[req_addr_lsb(DATA_W) +: ADDR_W];
  assign req_wdata  = req[req_wdata_lsb(DATA_W) +: DATA_W];
  assign req_wstrb  = req[REQ_WSTRB_LSB +: STRB_W];

  // Byte offset and high address bits are don't-care: addresses wrap
  logic unused_addr;
  assign unused_addr = ^req_addr;

  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              accept;
  logic              rd_accept;

  assign accept    = req_avalid & ready;
  assign rd_accept = accept & (req_wstrb == '0);

  iob_ram_sp_be #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .en_i   (accept),
    .we_i   (req_wstrb),
    .addr_i (req_addr[MEM_ADDR_W+1:2]),
    .d_i    (req_wdata),
    .d_o    (ram_rdata)
  );

  if (W_EFF > 0) begin : g_wait
    localparam int              CNT_W    = $clog2(W_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W_EFF - 1);

    resp_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ready_q;
    logic              rd_pend_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    // Responder FSM: accept in IDLE, count wait states in BUSY, then answer.
    // rdata is captured from the RAM only when the read completes so the
    // visible value never changes while rvalid is low.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        ready_q   <= 1'b1;
        rd_pend_q <= 1'b0;
        rvalid_q  <= 1'b0;
        rdata_q   <= '0;
      end else begin
        rvalid_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (accept) begin
              state_q   <= BUSY;
              cnt_q     <= CNT_LOAD;
              ready_q   <= 1'b0;
              rd_pend_q <= rd_accept;
            end
          end
          BUSY: begin
            if (cnt_q == '0) begin
              state_q   <= IDLE;
              ready_q   <= 1'b1;
              rvalid_q  <= rd_pend_q;
              rd_pend_q <= 1'b0;
              if (rd_pend_q) rdata_q <= ram_rdata;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign ready  = ready_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
  end else begin : g_nowait
    logic rvalid_q;

    // Zero wait states: always ready, rvalid one cycle behind a read accept
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rvalid_q <= 1'b0;
      else         rvalid_q <= rd_accept;
    end

    assign ready  = 1'b1;
    assign rvalid = rvalid_q;
    assign rdata  = ram_rdata;
  end

  assign resp[RESP_READY_BIT]               = ready;
  assign resp[RESP_RVALID_BIT]              = rvalid;
  assign resp[RESP_RDATA_LSB +: DATA_W]     = rdata;

endmodule
